// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner
// Brief    : Column-scanned matrix keypad front end with whole-frame debounce
//            and single-key press/release events.
// Revision : 1.0
// ============================================================================
module keypad_matrix_scanner #(
    parameter int N_COLS   = 4,
    parameter int N_ROWS   = 5,
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 4,
    localparam int RW      = $clog2(N_ROWS),
    localparam int CW      = $clog2(N_COLS),
    localparam int CODE_W  = RW + CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    input  logic [N_ROWS-1:0] row_in,
    output logic [N_COLS-1:0] col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              multi_key
);

    localparam int c_keys = N_ROWS * N_COLS;
    localparam int c_sw   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_dw   = $clog2(DEBOUNCE);

    localparam logic [c_sw-1:0] c_settle_last = c_sw'(SETTLE - 1);
    localparam logic [c_dw-1:0] c_stable_max  = c_dw'(DEBOUNCE - 1);
    localparam logic [c_dw-1:0] c_stable_arm  = c_dw'(DEBOUNCE - 2);
    localparam logic [CW-1:0]   c_col_last    = CW'(N_COLS - 1);

    localparam logic [1:0] c_st_drive  = 2'd0;
    localparam logic [1:0] c_st_sample = 2'd1;
    localparam logic [1:0] c_st_eval   = 2'd2;

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_next;
    logic                          r_active;
    logic [CW-1:0]                 r_col_idx;
    logic [c_sw-1:0]               r_settle;
    logic [c_dw-1:0]               r_stable;
    logic [N_ROWS-1:0]             r_row_meta;
    logic [N_ROWS-1:0]             r_row_sync;
    logic [N_COLS-1:0][N_ROWS-1:0] r_frame;
    logic [N_COLS-1:0][N_ROWS-1:0] r_prev;
    logic [N_COLS-1:0][N_ROWS-1:0] r_committed;
    logic [CODE_W-1:0]             r_key_code;
    logic                          r_key_valid;
    logic                          r_key_release;
    logic                          r_key_held;
    logic                          r_multi_key;

    logic                          w_run;
    logic [c_keys-1:0]             w_flat;
    logic                          w_one;
    logic                          w_multi;
    logic                          w_same;
    logic                          w_commit;
    logic [CODE_W-1:0]             w_code;
    logic [N_COLS-1:0]             w_col_out;

    // r_active lags scan_en by one clock so a restart always begins at col 0
    assign w_run = scan_en & r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_drive;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_run) begin
            w_state_next = c_st_drive;
        end else begin
            case (r_state)
                c_st_drive:  if (r_settle == c_settle_last) w_state_next = c_st_sample;
                c_st_sample: w_state_next = (r_col_idx == c_col_last) ? c_st_eval : c_st_drive;
                c_st_eval:   w_state_next = c_st_drive;
                default:     w_state_next = c_st_drive;
            endcase
        end
    end

    always_comb begin
        w_col_out = '1;
        if (r_active && (r_state != c_st_eval)) begin
            w_col_out[r_col_idx] = 1'b0;
        end
    end

    // Descending scan so the lowest row, then lowest column, wins
    always_comb begin
        w_flat   = r_frame;
        w_one    = (w_flat != '0) && ((w_flat & (w_flat - c_keys'(1))) == '0);
        w_multi  = (w_flat != '0) && !w_one;
        w_same   = (r_frame == r_prev);
        w_commit = w_same && (r_stable >= c_stable_arm);
        w_code   = '0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            for (int c = N_COLS - 1; c >= 0; c--) begin
                if (r_frame[c][r]) w_code = {RW'(r), CW'(c)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_col_idx     <= '0;
            r_settle      <= '0;
            r_stable      <= '0;
            r_row_meta    <= '0;
            r_row_sync    <= '0;
            r_frame       <= '0;
            r_prev        <= '0;
            r_committed   <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
            r_multi_key   <= 1'b0;
        end else begin
            r_active      <= scan_en;
            r_row_meta    <= row_in;
            r_row_sync    <= r_row_meta;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            if (!w_run) begin
                r_col_idx <= '0;
                r_settle  <= '0;
                r_frame   <= '0;
            end else begin
                case (r_state)
                    c_st_drive: begin
                        r_settle <= (r_settle == c_settle_last) ? '0 : r_settle + c_sw'(1);
                    end
                    c_st_sample: begin
                        r_frame[r_col_idx] <= ~r_row_sync;
                        r_col_idx <= (r_col_idx == c_col_last) ? '0 : r_col_idx + CW'(1);
                    end
                    c_st_eval: begin
                        if (w_same) begin
                            r_stable <= (r_stable == c_stable_max) ? r_stable : r_stable + c_dw'(1);
                        end else begin
                            r_stable <= '0;
                        end
                        r_prev <= r_frame;
                        if (w_commit) begin
                            r_committed   <= r_frame;
                            r_key_held    <= w_one;
                            r_multi_key   <= w_multi;
                            r_key_release <= r_key_held && (w_flat == '0);
                            if (w_one && (r_frame != r_committed)) begin
                                r_key_valid <= 1'b1;
                                r_key_code  <= w_code;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign col_out     = w_col_out;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_release;
    assign key_held    = r_key_held;
    assign multi_key   = r_multi_key;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_matrix_scanner
// Brief    : Directed bench for keypad_matrix_scanner with a frame-level
//            reference model compared every cycle.
// Revision : 1.0
// ============================================================================
module tb_keypad_matrix_scanner;

    localparam int NC    = 4;
    localparam int NR    = 5;
    localparam int ST    = 2;
    localparam int DB    = 3;
    localparam int FRAME = NC * (ST + 1) + 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          scan_en = 1'b0;
    logic [NR-1:0] row_in;
    logic [NC-1:0] col_out;
    logic [4:0]    key_code;
    logic          key_valid;
    logic          key_release;
    logic          key_held;
    logic          multi_key;

    logic [NC-1:0] keys [NR] = '{default: '0};

    int vectors    = 0;
    int miscompares = 0;
    int n_valid    = 0;
    int n_release  = 0;
    int codes [$];

    // Reference model state; frame bit index is row*NC+col
    bit              m_active = 1'b0;
    int              m_phase  = 0;
    int              m_stable = 0;
    logic [NR*NC-1:0] m_frame = '0;
    logic [NR*NC-1:0] m_prev  = '0;
    logic [NR*NC-1:0] m_comm  = '0;
    bit              e_valid = 1'b0, e_release = 1'b0, e_held = 1'b0, e_multi = 1'b0;
    logic [4:0]      e_code  = '0;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .N_COLS  (NC),
        .N_ROWS  (NR),
        .SETTLE  (ST),
        .DEBOUNCE(DB)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en    (scan_en),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held),
        .multi_key  (multi_key)
    );

    // Passive keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        for (int r = 0; r < NR; r++) row_in[r] = ~|(keys[r] & ~col_out);
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] exp_col();
        logic [NC-1:0] one;
        one = NC'(1);
        if (m_active && (m_phase < FRAME - 1)) return ~(one << (m_phase / (ST + 1)));
        return '1;
    endfunction

    task automatic model_commit();
        int n, old;
        n   = $countones(m_frame);
        old = $countones(m_comm);
        if (n == 1 && m_frame != m_comm) begin
            e_valid = 1'b1;
            for (int i = 0; i < NR * NC; i++) begin
                if (m_frame[i]) begin
                    e_code = {3'(i / NC), 2'(i % NC)};
                    break;
                end
            end
        end
        e_release = (old == 1) && (n == 0);
        e_held    = (n == 1);
        e_multi   = (n >= 2);
        m_comm    = m_frame;
    endtask

    // Model: column c's rows are what the keypad showed two cycles before its sample slot
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0; m_phase = 0; m_stable = 0;
            m_frame = '0; m_prev = '0; m_comm = '0;
            e_valid = 1'b0; e_release = 1'b0; e_held = 1'b0; e_multi = 1'b0; e_code = '0;
        end else if (!scan_en) begin
            m_active = 1'b0; m_phase = 0; e_valid = 1'b0; e_release = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1; m_phase = 0; e_valid = 1'b0; e_release = 1'b0;
        end else begin
            e_valid = 1'b0; e_release = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (m_phase == c * (ST + 1) + ST - 2) begin
                    for (int r = 0; r < NR; r++) m_frame[r*NC + c] = keys[r][c];
                end
            end
            if (m_phase == FRAME - 1) begin
                if (m_frame == m_prev) begin
                    m_stable = (m_stable < DB - 1) ? m_stable + 1 : DB - 1;
                    if (m_stable == DB - 1) model_commit();
                end else begin
                    m_stable = 0;
                end
                m_prev = m_frame;
            end
            m_phase = (m_phase + 1) % FRAME;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("col_out", col_out, exp_col());
        chk("key_valid", key_valid, e_valid);
        chk("key_release", key_release, e_release);
        chk("key_held", key_held, e_held);
        chk("multi_key", multi_key, e_multi);
        chk("key_code", key_code, e_code);
        if (key_valid) begin
            n_valid++;
            codes.push_back(int'(key_code));
        end
        if (key_release) n_release++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [NC-1:0] pat, input string nm);
        for (int k = 0; k < 4 * FRAME; k++) begin
            @(posedge clk);
            #1;
            if (col_out == pat) break;
        end
        chk(nm, col_out, pat);
    endtask

    task automatic clr();
        n_valid = 0;
        n_release = 0;
        codes.delete();
    endtask

    initial begin
        tick(3);
        chk("reset col_out", col_out, 4'hF);
        chk("reset key_code", key_code, 0);
        chk("reset key_held", key_held, 0);
        rst_n = 1'b1;
        scan_en = 1'b1;
        tick(1);
        chk("first col after release", col_out, 4'b1110);

        // 1: idle scan
        clr();
        tick(4 * FRAME);
        chk("t1 valid count", n_valid, 0);
        chk("t1 release count", n_release, 0);
        chk("t1 multi_key", multi_key, 0);

        // 2: clean press and release of row2/col1
        clr();
        keys[2][1] = 1'b1;
        tick(5 * FRAME);
        chk("t2 valid count", n_valid, 1);
        chk("t2 key_code", key_code, 5'b010_01);
        chk("t2 key_held", key_held, 1);
        clr();
        keys[2][1] = 1'b0;
        tick(5 * FRAME);
        chk("t2 release count", n_release, 1);
        chk("t2 valid after release", n_valid, 0);
        chk("t2 key_held after release", key_held, 0);
        chk("t2 key_code kept", key_code, 5'b010_01);

        // 3: bounce row4/col3 every 7 cycles, starting on an EVAL cycle
        clr();
        wait_col(4'hF, "t3 sync to eval");
        keys[4][3] = 1'b1;
        for (int i = 1; i < 60; i++) begin
            tick(1);
            keys[4][3] = ((i / 7) % 2 == 0);
        end
        tick(1);
        keys[4][3] = 1'b1;
        chk("t3 no pulse during bounce", n_valid, 0);
        tick(4 * FRAME);
        chk("t3 valid count", n_valid, 1);
        chk("t3 release count", n_release, 0);
        chk("t3 key_code", key_code, 5'b100_11);
        keys = '{default: '0};
        tick(5 * FRAME);

        // 4: two keys, then one released
        clr();
        keys[0][0] = 1'b1;
        keys[1][2] = 1'b1;
        tick(5 * FRAME);
        chk("t4 multi_key", multi_key, 1);
        chk("t4 key_held", key_held, 0);
        chk("t4 valid while multi", n_valid, 0);
        keys[1][2] = 1'b0;
        tick(5 * FRAME);
        chk("t4 valid count", n_valid, 1);
        chk("t4 key_code", key_code, 5'b000_00);
        chk("t4 multi cleared", multi_key, 0);
        keys = '{default: '0};
        tick(5 * FRAME);

        // 5: direct switch row3/col0 -> row3/col2
        clr();
        keys[3][0] = 1'b1;
        tick(5 * FRAME);
        keys[3][0] = 1'b0;
        keys[3][2] = 1'b1;
        tick(5 * FRAME);
        chk("t5 valid count", n_valid, 2);
        chk("t5 release count", n_release, 0);
        if (codes.size() >= 2) begin
            chk("t5 first code", codes[0], 5'b011_00);
            chk("t5 second code", codes[1], 5'b011_10);
        end

        // 6: reset during col 2 drive with key held, then scan_en drop mid-frame
        wait_col(4'b1011, "t6 reach col2");
        rst_n = 1'b0;
        #1;
        chk("t6 col_out in reset", col_out, 4'hF);
        chk("t6 key_held in reset", key_held, 0);
        chk("t6 key_code in reset", key_code, 0);
        tick(2);
        rst_n = 1'b1;
        clr();
        tick(1);
        chk("t6 restart col0", col_out, 4'b1110);
        tick(5 * FRAME);
        chk("t6 valid after reset", n_valid, 1);
        chk("t6 key_code after reset", key_code, 5'b011_10);
        wait_col(4'b1101, "t6 reach col1");
        scan_en = 1'b0;
        tick(1);
        chk("t6 col_out scan off", col_out, 4'hF);
        tick(4);
        chk("t6 key_held holds", key_held, 1);
        clr();
        scan_en = 1'b1;
        tick(1);
        chk("t6 scan restart col0", col_out, 4'b1110);
        tick(5 * FRAME);
        chk("t6 no pulse on re-commit", n_valid, 0);
        chk("t6 key_held final", key_held, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
